// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm time-of-day core.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam int MAX_HR        = 23;
    localparam int MAX_MS        = 59;
    localparam int RST_ALARM_HR  = 6;
    localparam int RST_ALARM_MIN = 0;

    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;

endpackage

// File: rtl/alarm_timekeeper_mod_counter.sv
// Modulo-(MAX+1) up counter with synchronous clear; wrap flags the MAX->0 step.
module mod_counter
    import alarm_pkg::*;
#(
    parameter int MAX     = MAX_MS,
    parameter int W       = 6,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         wrap
);

    assign wrap = en && (value == W'(MAX));

    // Count register; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= W'(RST_VAL);
        end else if (clr) begin
            value <= {W{1'b0}};
        end else if (en) begin
            value <= wrap ? {W{1'b0}} : value + W'(1);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/alarm_timekeeper.sv
// 24-hour timekeeper with settable alarm and ring/snooze control,
// advanced by rising edges of the 1 Hz divider output sampled in clk.
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic [1:0] set_mode,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       sec_tick,
    output logic       ringing
);

    localparam int SNZ_LOAD = SNOOZE_MIN * 60;
    localparam int RW       = $clog2(RING_SEC + 1);
    localparam int SW       = $clog2(SNZ_LOAD + 1);

    logic          sec_q;
    logic          tick_d;
    logic          set_time_mode;
    logic          set_alarm_mode;
    logic          run_tick;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hr_wrap;
    logic          ahr_wrap;
    logic          amin_wrap;
    logic [2:0]    unused_wraps;
    logic          alarm_hit;
    alarm_state_t  state;
    alarm_state_t  state_n;
    logic [RW-1:0] ring_cnt;
    logic [RW-1:0] ring_n;
    logic [SW-1:0] snz_cnt;
    logic [SW-1:0] snz_n;

    assign set_time_mode  = (set_mode == MODE_SET_TIME);
    assign set_alarm_mode = (set_mode == MODE_SET_ALARM);
    assign run_tick       = sec_tick && !set_time_mode;
    assign unused_wraps   = {hr_wrap, ahr_wrap, amin_wrap};

    mod_counter #(.MAX(MAX_MS), .W(6), .RST_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .clr(set_time_mode), .en(run_tick),
        .value(seconds), .wrap(sec_wrap)
    );

    mod_counter #(.MAX(MAX_MS), .W(6), .RST_VAL(0)) u_min (
        .clk(clk), .rst(rst), .clr(1'b0),
        .en((run_tick && sec_wrap) || (set_time_mode && inc_min)),
        .value(minutes), .wrap(min_wrap)
    );

    // Manual minute wraps never carry: the carry term requires a running tick.
    mod_counter #(.MAX(MAX_HR), .W(5), .RST_VAL(0)) u_hr (
        .clk(clk), .rst(rst), .clr(1'b0),
        .en((run_tick && sec_wrap && min_wrap) || (set_time_mode && inc_hr)),
        .value(hours), .wrap(hr_wrap)
    );

    mod_counter #(.MAX(MAX_HR), .W(5), .RST_VAL(RST_ALARM_HR)) u_alarm_hr (
        .clk(clk), .rst(rst), .clr(1'b0), .en(set_alarm_mode && inc_hr),
        .value(alarm_hr), .wrap(ahr_wrap)
    );

    mod_counter #(.MAX(MAX_MS), .W(6), .RST_VAL(RST_ALARM_MIN)) u_alarm_min (
        .clk(clk), .rst(rst), .clr(1'b0), .en(set_alarm_mode && inc_min),
        .value(alarm_min), .wrap(amin_wrap)
    );

    // Rising-edge detect on sec_clk; tick_d marks a time update by a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q    <= 1'b0;
            sec_tick <= 1'b0;
            tick_d   <= 1'b0;
        end else begin
            sec_q    <= sec_clk;
            sec_tick <= sec_clk & ~sec_q;
            tick_d   <= run_tick;
        end
    end

    // Only a freshly ticked-into match fires, so set-time or a stale match cannot.
    assign alarm_hit = alarm_en && !set_time_mode && tick_d &&
                       (hours == alarm_hr) && (minutes == alarm_min) &&
                       (seconds == 6'd0);

    // Next-state and counter updates for the ring/snooze machine.
    always_comb begin
        state_n = state;
        ring_n  = ring_cnt;
        snz_n   = snz_cnt;
        if (!alarm_en || set_time_mode) begin
            state_n = IDLE;
            ring_n  = {RW{1'b0}};
            snz_n   = {SW{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    ring_n = {RW{1'b0}};
                    snz_n  = {SW{1'b0}};
                    if (alarm_hit) begin
                        state_n = RING;
                    end else begin
                        state_n = IDLE;
                    end
                end
                RING: begin
                    if (stop) begin
                        state_n = IDLE;
                        ring_n  = {RW{1'b0}};
                    end else if (snooze) begin
                        state_n = SNOOZE;
                        ring_n  = {RW{1'b0}};
                        snz_n   = SW'(SNZ_LOAD);
                    end else if (sec_tick) begin
                        if (ring_cnt >= RW'(RING_SEC - 1)) begin
                            state_n = IDLE;
                            ring_n  = {RW{1'b0}};
                        end else begin
                            ring_n = ring_cnt + RW'(1);
                        end
                    end else begin
                        state_n = RING;
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_n = IDLE;
                        snz_n   = {SW{1'b0}};
                    end else if (snz_cnt == {SW{1'b0}}) begin
                        state_n = RING;
                        ring_n  = {RW{1'b0}};
                    end else if (sec_tick) begin
                        snz_n = snz_cnt - SW'(1);
                        if (snz_cnt == SW'(1)) begin
                            state_n = RING;
                            ring_n  = {RW{1'b0}};
                        end else begin
                            state_n = SNOOZE;
                        end
                    end else begin
                        state_n = SNOOZE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    ring_n  = {RW{1'b0}};
                    snz_n   = {SW{1'b0}};
                end
            endcase
        end
    end

    // State, counters and the registered ringing flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ring_cnt <= {RW{1'b0}};
            snz_cnt  <= {SW{1'b0}};
            ringing  <= 1'b0;
        end else begin
            state    <= state_n;
            ring_cnt <= ring_n;
            snz_cnt  <= snz_n;
            ringing  <= (state_n == RING);
        end
    end

endmodule
